// File: rtl/seq_alu.sv
// Sequential ALU with a valid/ready handshake at both ends. Single-cycle logic ops,
// add and subtract; an unsigned multiply that retires one multiplier bit per cycle.
module seq_alu #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cntrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_MUL  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    state_t state, state_nx;

    logic [WIDTH-1:0] mcand, mplier, acc, acc_nx;
    logic [CW-1:0]    cnt;
    logic             accept, last;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_r;
    logic             alu_v, alu_c;

    assign in_ready = reset && ((state == IDLE) || (state == DONE && out_ready));
    assign accept   = in_valid && in_ready;
    assign busy     = (state == MUL);
    assign last     = (state == MUL) && (cnt == LAST);
    assign acc_nx   = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = (cntrl == OP_MUL) ? MUL : DONE;
            MUL:  if (last) state_nx = DONE;
            DONE: begin
                if (accept)         state_nx = (cntrl == OP_MUL) ? MUL : DONE;
                else if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Single-cycle ops; multiply and reserved fall through to a zero result.
    always_comb begin
        sum   = '0;
        alu_r = '0;
        alu_v = 1'b0;
        alu_c = 1'b0;
        case (cntrl)
            OP_PASS: alu_r = B;
            OP_ADD: begin
                sum   = {1'b0, A} + {1'b0, B};
                alu_r = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (A[WIDTH-1] == B[WIDTH-1]) && (alu_r[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                sum   = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
                alu_r = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (A[WIDTH-1] != B[WIDTH-1]) && (alu_r[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  alu_r = A & B;
            OP_OR:   alu_r = A | B;
            OP_XOR:  alu_r = A ^ B;
            default: alu_r = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result    <= '0;
            negative  <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            carry_out <= 1'b0;
            out_valid <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else if (accept) begin
            if (cntrl == OP_MUL) begin
                mcand     <= A;
                mplier    <= B;
                acc       <= '0;
                cnt       <= '0;
                out_valid <= 1'b0;
            end else begin
                result    <= alu_r;
                negative  <= alu_r[WIDTH-1];
                zero      <= (alu_r == '0);
                overflow  <= alu_v;
                carry_out <= alu_c;
                out_valid <= 1'b1;
            end
        end else if (state == MUL) begin
            // Operands live only in the shift registers, so input changes here are ignored.
            acc    <= acc_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (last) begin
                result    <= acc_nx;
                negative  <= acc_nx[WIDTH-1];
                zero      <= (acc_nx == '0);
                overflow  <= 1'b0;
                carry_out <= 1'b0;
                out_valid <= 1'b1;
            end
        end else if (state == DONE && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: a 64-bit and an 8-bit instance, directed corner cases then
// random operations checked against an arithmetic reference model.
module tb_seq_alu;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  cntrl = 3'b000;
    logic [63:0] A = '0;
    logic [63:0] B = '0;
    logic        sel = 1'b0;      // 0 selects the 64-bit instance, 1 the 8-bit one

    logic        iv64, iv8;
    logic        ir64, ir8, ov64, ov8, n64, n8, z64, z8, v64, v8, c64, c8, b64, b8;
    logic [63:0] r64;
    logic [7:0]  r8;

    logic        o_ready, o_valid, o_neg, o_zero, o_ovf, o_carry, o_busy;
    logic [63:0] o_res;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [63:0] r;
        logic        n, z, v, c;
    } exp_t;

    exp_t last_obs;

    always #5 clk = ~clk;

    assign iv64 = in_valid & ~sel;
    assign iv8  = in_valid & sel;

    seq_alu #(.WIDTH(64)) u64 (
        .clk(clk), .reset(reset), .in_valid(iv64), .in_ready(ir64),
        .A(A), .B(B), .cntrl(cntrl), .out_valid(ov64), .out_ready(out_ready),
        .result(r64), .negative(n64), .zero(z64), .overflow(v64),
        .carry_out(c64), .busy(b64)
    );

    seq_alu #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
        .A(A[7:0]), .B(B[7:0]), .cntrl(cntrl), .out_valid(ov8), .out_ready(out_ready),
        .result(r8), .negative(n8), .zero(z8), .overflow(v8),
        .carry_out(c8), .busy(b8)
    );

    assign o_ready = sel ? ir8 : ir64;
    assign o_valid = sel ? ov8 : ov64;
    assign o_res   = sel ? {56'b0, r8} : r64;
    assign o_neg   = sel ? n8 : n64;
    assign o_zero  = sel ? z8 : z64;
    assign o_ovf   = sel ? v8 : v64;
    assign o_carry = sel ? c8 : c64;
    assign o_busy  = sel ? b8 : b64;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference: signed values are sign-extended into wide integers and range-checked.
    function automatic exp_t model(input int w, input logic [2:0] op,
                                   input logic [63:0] a_in, input logic [63:0] b_in);
        exp_t e;
        logic [63:0] mask, a, b;
        logic signed [63:0] t;
        logic signed [65:0] sa, sb, ss, smax, smin, one;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        a = a_in & mask;
        b = b_in & mask;
        t = $signed(a << (64 - w));
        t = t >>> (64 - w);
        sa = t;
        t = $signed(b << (64 - w));
        t = t >>> (64 - w);
        sb = t;
        one  = 66'sd1;
        smax = (one <<< (w - 1)) - one;
        smin = -(one <<< (w - 1));
        e = '0;
        case (op)
            3'd0: e.r = b;
            3'd1: e.r = (a * b) & mask;
            3'd2: begin
                e.r = (a + b) & mask;
                e.c = ({1'b0, a} + {1'b0, b}) > {1'b0, mask};
                ss  = sa + sb;
                e.v = (ss > smax) || (ss < smin);
            end
            3'd3: begin
                e.r = (a - b) & mask;
                e.c = (a >= b);
                ss  = sa - sb;
                e.v = (ss > smax) || (ss < smin);
            end
            3'd4: e.r = a & b;
            3'd5: e.r = a | b;
            3'd6: e.r = a ^ b;
            default: e.r = '0;
        endcase
        e.z = (e.r == 64'd0);
        e.n = e.r[w-1];
        return e;
    endfunction

    task automatic check_outputs(input string tag, input exp_t e);
        chk({tag, "_result"}, o_res, e.r);
        chk1({tag, "_negative"}, o_neg, e.n);
        chk1({tag, "_zero"}, o_zero, e.z);
        chk1({tag, "_overflow"}, o_ovf, e.v);
        chk1({tag, "_carry"}, o_carry, e.c);
    endtask

    // Issue one op from an idle DUT, check it, hold the result for 'hold' cycles, then drain.
    task automatic do_op(input logic s, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, input int hold);
        exp_t e;
        int   w;
        int   cyc;
        w = s ? 8 : 64;
        e = model(w, op, a, b);
        sel = s;
        cntrl = op;
        A = a;
        B = b;
        in_valid = 1'b1;
        out_ready = 1'b0;
        #1;
        chk1("in_ready_idle", o_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = {$urandom, $urandom};
        B = {$urandom, $urandom};
        cntrl = 3'($urandom);
        if (op == 3'b001) begin
            cyc = 0;
            while (!o_valid && cyc < 200) begin
                chk1("busy_in_mul", o_busy, 1'b1);
                @(posedge clk);
                #1;
                cyc++;
            end
            chk("mul_latency", 64'(cyc), 64'(w));
        end
        chk1("out_valid", o_valid, 1'b1);
        chk1("busy_done", o_busy, 1'b0);
        check_outputs("op", e);
        last_obs = '{r: o_res, n: o_neg, z: o_zero, v: o_ovf, c: o_carry};
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk1("hold_valid", o_valid, 1'b1);
            chk("hold_result", o_res, e.r);
            chk1("hold_in_ready", o_ready, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        chk1("in_ready_done", o_ready, 1'b1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk1("drained", o_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        // Reset state on both instances while reset is held low.
        #3 reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_result", o_res, 64'd0);
            chk1("rst_valid", o_valid, 1'b0);
            chk1("rst_in_ready", o_ready, 1'b0);
            chk1("rst_busy", o_busy, 1'b0);
            chk1("rst_zero", o_zero, 1'b0);
            chk1("rst_neg", o_neg, 1'b0);
        end
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk1("post_rst_in_ready", o_ready, 1'b1);
        end

        // Signed overflow on add.
        do_op(1'b0, 3'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0);
        chk("add_ovf_r", last_obs.r, 64'h8000_0000_0000_0000);
        chk1("add_ovf_n", last_obs.n, 1'b1);
        chk1("add_ovf_v", last_obs.v, 1'b1);
        chk1("add_ovf_c", last_obs.c, 1'b0);
        chk1("add_ovf_z", last_obs.z, 1'b0);

        // Subtract: equal operands and a borrow.
        do_op(1'b0, 3'd3, 64'd5, 64'd5, 0);
        chk("sub_eq_r", last_obs.r, 64'd0);
        chk1("sub_eq_z", last_obs.z, 1'b1);
        chk1("sub_eq_c", last_obs.c, 1'b1);
        chk1("sub_eq_v", last_obs.v, 1'b0);
        do_op(1'b0, 3'd3, 64'd0, 64'd1, 0);
        chk("sub_brw_r", last_obs.r, 64'hFFFF_FFFF_FFFF_FFFF);
        chk1("sub_brw_n", last_obs.n, 1'b1);
        chk1("sub_brw_c", last_obs.c, 1'b0);

        // Reserved opcode.
        do_op(1'b1, 3'd7, 64'hA5, 64'h5A, 0);
        chk("rsv8_r", last_obs.r, 64'd0);
        chk1("rsv8_z", last_obs.z, 1'b1);
        do_op(1'b0, 3'd7, {$urandom, $urandom}, {$urandom, $urandom}, 1);
        chk("rsv64_r", last_obs.r, 64'd0);
        chk1("rsv64_z", last_obs.z, 1'b1);

        // 8-bit multiply; do_op scrambles A/B/cntrl while it iterates.
        do_op(1'b1, 3'd1, 64'h0F, 64'h11, 0);
        chk("mul8_r", last_obs.r, 64'hFF);
        chk1("mul8_n", last_obs.n, 1'b1);

        // XOR held under backpressure, then back-to-back OR on the releasing edge.
        sel = 1'b1;
        cntrl = 3'd6;
        A = 64'hF0;
        B = 64'hFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("xor_r", o_res, 64'h0F);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("xor_hold_r", o_res, 64'h0F);
            chk1("xor_hold_valid", o_valid, 1'b1);
            chk1("xor_hold_in_ready", o_ready, 1'b0);
        end
        cntrl = 3'd5;
        A = 64'h30;
        B = 64'h03;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        chk1("b2b_in_ready", o_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        e = model(8, 3'd5, 64'h30, 64'h03);
        chk1("b2b_valid", o_valid, 1'b1);
        check_outputs("b2b", e);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk1("b2b_drained", o_valid, 1'b0);

        // Reset in the middle of a 64-bit multiply.
        sel = 1'b0;
        cntrl = 3'd1;
        A = {$urandom, $urandom};
        B = {$urandom, $urandom};
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        chk1("mid_mul_busy", o_busy, 1'b1);
        reset = 1'b0;
        #1;
        chk("mrst_result", o_res, 64'd0);
        chk1("mrst_valid", o_valid, 1'b0);
        chk1("mrst_busy", o_busy, 1'b0);
        chk1("mrst_in_ready", o_ready, 1'b0);
        chk1("mrst_flags", o_neg | o_zero | o_ovf | o_carry, 1'b0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        chk1("mrst_rel_in_ready", o_ready, 1'b1);
        chk1("mrst_rel_valid", o_valid, 1'b0);
        do_op(1'b0, 3'd0, {$urandom, $urandom}, 64'h1234, 0);
        chk("pass_after_rst", last_obs.r, 64'h1234);

        // Random operations on both widths.
        for (int i = 0; i < 30; i++) begin
            do_op(1'($urandom), 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                  int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, giving the operand/result width in bits (legal range 8..64).
REQ-002 The block SHALL have input clk, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have input reset, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have input in_valid, 1 bit, meaning an operation is offered.
REQ-005 The block SHALL have output in_ready, 1 bit, meaning an offered operation will be accepted this cycle.
REQ-006 The block SHALL have inputs A and B, WIDTH bits each, the operands.
REQ-007 The block SHALL have input cntrl, 3 bits, the operation select.
REQ-008 The block SHALL have output out_valid, 1 bit, meaning result and flags are valid.
REQ-009 The block SHALL have input out_ready, 1 bit, meaning the consumer takes the result this cycle.
REQ-010 The block SHALL have output result, WIDTH bits, the registered result.
REQ-011 The block SHALL have outputs negative, zero, overflow and carry_out, 1 bit each, the registered flags.
REQ-012 The block SHALL have output busy, 1 bit, high while a multiply is iterating.

Function
REQ-013 cntrl SHALL decode as 000 pass B, 001 multiply, 010 add, 011 subtract, 100 AND, 101 OR, 110 XOR, 111 reserved.
REQ-014 An operation SHALL be accepted on a rising edge where in_valid and in_ready are both high; A, B and cntrl SHALL be captured on that edge.
REQ-015 The FSM SHALL have states IDLE, MUL and DONE; in_ready SHALL be high in IDLE, and in DONE when out_ready is high; otherwise low.
REQ-016 Non-multiply ops SHALL be computed at acceptance, go to DONE, and raise out_valid on the accepting edge: one cycle of latency.
REQ-017 Multiply SHALL go to MUL and iterate shift-add, one bit per cycle, for WIDTH cycles; it SHALL enter DONE with out_valid high on edge E0+WIDTH, where E0 is the accepting edge.
REQ-018 busy SHALL be high exactly while in MUL.
REQ-019 Multiply SHALL return the low WIDTH bits of the unsigned product; overflow and carry_out SHALL be 0.
REQ-020 Add SHALL compute A+B mod 2^WIDTH; carry_out SHALL be the carry out of bit WIDTH-1; overflow SHALL be the signed two's-complement overflow.
REQ-021 Subtract SHALL compute A+~B+1 mod 2^WIDTH; carry_out SHALL be the carry out of that sum (1 means no borrow); overflow SHALL be signed overflow.
REQ-022 For pass, AND, OR and XOR, overflow and carry_out SHALL be 0.
REQ-023 For every op, negative SHALL equal result[WIDTH-1], and zero SHALL be 1 when result is all zero.
REQ-024 Reserved cntrl 111 SHALL produce result 0, zero 1 and the other flags 0, with one cycle of latency.
REQ-025 In DONE with out_ready low, result, flags and out_valid SHALL hold stable.
REQ-026 In DONE with out_ready high and no new acceptance, the next state SHALL be IDLE with out_valid 0.
REQ-027 In DONE with out_ready high and in_valid high, the new op SHALL be accepted on the same edge (back-to-back); out_valid stays high for a non-multiply op and goes low for a multiply.
REQ-028 Inputs SHALL be ignored in MUL; A, B and cntrl changes during MUL SHALL NOT affect the product.

Reset
REQ-029 reset low SHALL immediately force state IDLE and multiply counter 0.
REQ-030 reset low SHALL immediately force result 0, negative 0, zero 0, overflow 0, carry_out 0, out_valid 0 and busy 0.
REQ-031 in_ready SHALL be 0 while reset is low and 1 from the first cycle after reset deasserts.
REQ-032 Reset during MUL or DONE SHALL discard the operation with no output handshake.

Verification
REQ-033 WIDTH=64, add A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> one cycle later result 0x8000_0000_0000_0000, negative 1, overflow 1, carry_out 0, zero 0.
REQ-034 WIDTH=64, subtract A=5, B=5 -> result 0, zero 1, carry_out 1, overflow 0; subtract A=0, B=1 -> result all ones, negative 1, carry_out 0.
REQ-035 WIDTH=8, multiply A=0x0F, B=0x11 -> busy for 8 cycles, out_valid at E0+8, result 0xFF, negative 1; changing A/B during MUL leaves the result unchanged.
REQ-036 Hold out_ready low for 5 cycles after an XOR of 0xF0^0xFF (WIDTH=8) -> result 0x0F held stable, in_ready 0; then out_ready high with in_valid high carrying an OR -> accepted on the same edge, next result valid the following cycle.
REQ-037 Assert reset mid-multiply (WIDTH=64, cycle 10) -> all outputs 0 immediately; after release, in_ready 1 and a pass-B of B=0x1234 returns 0x1234 after one cycle.
REQ-038 cntrl=111 with any A, B -> result 0, zero 1, other flags 0, one cycle of latency.
